// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART TX/RX blocks.
//   tx_state_e  - transmitter FSM states (BREAK/MARK only reachable when
//                 the design is built with UART_TX_BREAK_EN defined)
//   parity_e    - encoding of the 2-bit parity configuration field
//   calc_parity - parity bit over the low n bits of a payload
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK,
    MARK
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_MARK
  } parity_e;

  // Widest payload calc_parity accepts; callers zero-extend into it.
  localparam int PAR_DATA_W = 32;

  // Only bits [n-1:0] contribute, so unused upper payload bits never leak
  // into the parity of a short frame.
  function automatic logic calc_parity(input logic [PAR_DATA_W-1:0] data,
                                       input logic [5:0]            n,
                                       input parity_e               mode);
    logic even;
    even = 1'b0;
    for (int i = 0; i < PAR_DATA_W; i++) begin
      if (i < int'(n)) even = even ^ data[i];
    end
    case (mode)
      PAR_EVEN: calc_parity = even;
      PAR_ODD:  calc_parity = ~even;
      PAR_MARK: calc_parity = 1'b1;
      default:  calc_parity = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts baud ticks and flags the last tick of a bit period.
// Shared between the UART transmitter and receiver.
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-high reset
//   i_clr      hold the counter at zero (ticks ignored while set)
//   i_stick    one-cycle baud tick at OVER_SAMPLE x baud rate
//   o_bit_end  high on the tick that completes OVER_SAMPLE ticks
module uart_bit_timer #(
  parameter int OVER_SAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_stick,
  output logic o_bit_end
);

  localparam int CW = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVER_SAMPLE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_stick) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign o_bit_end = i_stick & ~i_clr & (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter.
// Frame: start bit, 1..DATA_MAX data bits LSB first, optional parity,
// one or two stop bits; each bit lasts OVER_SAMPLE i_stick ticks.
// Optional feature macro: UART_TX_BREAK_EN adds the i_break port and
// BREAK/MARK states (line held low while i_break, then one mark bit).
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_stick           baud tick from the shared baud generator
//   i_cfg_dbits       data bits minus one
//   i_cfg_par         00 none, 01 even, 10 odd, 11 mark
//   i_cfg_stop2       1 selects two stop bits
//   i_valid/o_ready   FIFO handshake; transfer when both high
//   i_data            payload, bit 0 transmitted first
//   o_tx_serial       registered serial line, idle high
//   o_busy            frame or break in progress
//   o_tx_done         one-cycle pulse after the last stop bit
//   i_break           (UART_TX_BREAK_EN only) request a line break
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_MAX    = 8,
  parameter int OVER_SAMPLE = 16,
  parameter int DBW         = $clog2(DATA_MAX)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stick,
  input  logic [DBW-1:0]      i_cfg_dbits,
  input  logic [1:0]          i_cfg_par,
  input  logic                i_cfg_stop2,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [DATA_MAX-1:0] i_data,
  output logic                o_tx_serial,
  output logic                o_busy,
  output logic                o_tx_done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                i_break
`endif
);

  tx_state_e           state;
  logic [DATA_MAX-1:0] sh_data;
  logic [DBW-1:0]      sh_dbits;
  logic                sh_par_on;
  logic                sh_par_bit;
  logic                sh_stop2;
  logic [DBW-1:0]      bit_idx;
  logic                stop_second;
  logic                bit_end;
  logic                timer_clr;

  // The timer restarts from zero whenever the line is not timing a bit,
  // so a tick landing on the accept (or break-release) cycle is ignored.
  assign timer_clr = (state == IDLE) || (state == BREAK);

  uart_bit_timer #(.OVER_SAMPLE(OVER_SAMPLE)) u_bit_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (timer_clr),
    .i_stick   (i_stick),
    .o_bit_end (bit_end)
  );

  assign o_ready = (state == IDLE);
  assign o_busy  = ~o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_tx_serial <= 1'b1;
      o_tx_done   <= 1'b0;
      sh_data     <= '0;
      sh_dbits    <= '0;
      sh_par_on   <= 1'b0;
      sh_par_bit  <= 1'b0;
      sh_stop2    <= 1'b0;
      bit_idx     <= '0;
      stop_second <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (i_break) begin
            o_tx_serial <= 1'b0;
            state       <= BREAK;
          end else
`endif
          if (i_valid) begin
            // Shadow the configuration so changes only affect the next frame.
            sh_data     <= i_data;
            sh_dbits    <= i_cfg_dbits;
            sh_par_on   <= (i_cfg_par != 2'b00);
            sh_par_bit  <= calc_parity(PAR_DATA_W'(i_data),
                                       6'(i_cfg_dbits) + 6'd1,
                                       parity_e'(i_cfg_par));
            sh_stop2    <= i_cfg_stop2;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            o_tx_serial <= 1'b0;
            state       <= START;
          end
        end
        START: begin
          if (bit_end) begin
            o_tx_serial <= sh_data[0];
            sh_data     <= sh_data >> 1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == sh_dbits) begin
              if (sh_par_on) begin
                o_tx_serial <= sh_par_bit;
                state       <= PARITY;
              end else begin
                o_tx_serial <= 1'b1;
                state       <= STOP;
              end
            end else begin
              bit_idx     <= bit_idx + DBW'(1);
              o_tx_serial <= sh_data[0];
              sh_data     <= sh_data >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            o_tx_serial <= 1'b1;
            state       <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (sh_stop2 && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state     <= IDLE;
              o_tx_done <= 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!i_break) begin
            o_tx_serial <= 1'b1;
            state       <= MARK;
          end
        end
        MARK: begin
          if (bit_end) state <= IDLE;
        end
`endif
        default: begin
          o_tx_serial <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg (DATA_MAX=8,
// OVER_SAMPLE=16). Expected frames are queued when a word is offered and
// compared bit by bit against the serial line as ticks arrive.
module tb_uart_tx_cfg;

  localparam int OS  = 16;
  localparam int DBW = 3;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  nbits;
  } frame_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           stick;
  logic [DBW-1:0] dbits;
  logic [1:0]     par;
  logic           stop2;
  logic           valid;
  logic [7:0]     data;
  logic           brk;
  logic           ready, tx, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_MAX(8), .OVER_SAMPLE(OS)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_stick     (stick),
    .i_cfg_dbits (dbits),
    .i_cfg_par   (par),
    .i_cfg_stop2 (stop2),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_data      (data),
    .o_tx_serial (tx),
    .o_busy      (busy),
    .o_tx_done   (done)
`ifdef UART_TX_BREAK_EN
    ,
    .i_break     (brk)
`endif
  );

  // Tick generator: one tick, then gap_cnt idle cycles (fixed or random).
  int gap_max  = 1;
  bit rand_gap = 1'b0;
  int gap_cnt  = 0;
  initial begin
    stick = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (gap_cnt > 0) begin
        stick   = 1'b0;
        gap_cnt = gap_cnt - 1;
      end else begin
        stick   = 1'b1;
        gap_cnt = rand_gap ? int'($urandom_range(gap_max, 1)) : gap_max;
      end
    end
  end

  function automatic frame_t model(input logic [7:0] d, input logic [DBW-1:0] db,
                                   input logic [1:0] p, input logic s2);
    frame_t f;
    int k;
    logic ev;
    f  = '0;
    k  = 1;                   // bit 0 is the start bit (0)
    ev = 1'b0;
    for (int i = 0; i <= int'(db); i++) begin
      f.bits[k] = d[i];
      ev = ev ^ d[i];
      k++;
    end
    if (p == 2'b01) begin f.bits[k] = ev;   k++; end
    if (p == 2'b10) begin f.bits[k] = ~ev;  k++; end
    if (p == 2'b11) begin f.bits[k] = 1'b1; k++; end
    f.bits[k] = 1'b1; k++;
    if (s2) begin f.bits[k] = 1'b1; k++; end
    f.nbits = 5'(k);
    return f;
  endfunction

  // Scoreboard / monitor state
  frame_t exp_q[$];
  frame_t cur;
  bit     active      = 1'b0;
  bit     done_due    = 1'b0;
  bit     frame_bad   = 1'b0;
  bit     in_frame    = 1'b0;
  int     scnt        = 0;
  int     bad_idx     = 0;
  logic   bad_val     = 1'b0;
  int     stk_run     = 0;
  int     last_sticks = 0;
  int     done_total  = 0;
  int     b2b_hits    = 0;

  always @(negedge clk) begin
    if (rst) begin
      active   = 1'b0;
      done_due = 1'b0;
      in_frame = 1'b0;
      exp_q.delete();
    end else begin
      // Independent tick count from accept to the observed done pulse.
      if (done) begin
        done_total++;
        if (in_frame) begin
          last_sticks = stk_run;
          in_frame    = 1'b0;
        end
      end else if (in_frame && stick) begin
        stk_run++;
      end

      if (done_due) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL done_pulse got=%b exp=1", done);
        end
        done_due = 1'b0;
      end

      if (active) begin
        if (!frame_bad && (tx !== cur.bits[scnt/OS] || ready !== 1'b0 ||
                           busy !== 1'b1 || done !== 1'b0)) begin
          frame_bad = 1'b1;
          bad_idx   = scnt;
          bad_val   = tx;
        end
        if (stick) scnt++;
        if (scnt == int'(cur.nbits) * OS) begin
          active   = 1'b0;
          done_due = 1'b1;
          checks++;
          if (frame_bad) begin
            failures++;
            $display("FAIL frame_line tick=%0d got=%b exp=%b (ready=%b busy=%b done=%b)",
                     bad_idx, bad_val, cur.bits[bad_idx/OS], ready, busy, done);
          end
        end
      end

      if (valid && ready) begin
        if (done) b2b_hits++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL accept got=unexpected exp=no_accept");
        end else begin
          cur       = exp_q.pop_front();
          active    = 1'b1;
          scnt      = 0;
          frame_bad = 1'b0;
          in_frame  = 1'b1;
          stk_run   = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [DBW-1:0] db,
                      input logic [1:0] p, input logic s2);
    int n;
    n = 0;
    @(posedge clk); #1;
    data  = d;
    dbits = db;
    par   = p;
    stop2 = s2;
    valid = 1'b1;
    exp_q.push_back(model(d, db, p, s2));
    @(negedge clk);
    while (!ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL send_timeout got=%0d exp=<5000", n);
    end
    @(posedge clk); #1;       // accepting edge has passed
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active || done_due) && n < 20000) begin
      @(negedge clk); #2;
      n++;
    end
    @(negedge clk); #2;
    checks++;
    if (n >= 20000 || ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle got=cycles%0d ready=%b exp=ready", tag, n, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx    !== 1'b1) begin failures++; $display("FAIL rst_tx got=%b exp=1", tx); end
    if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
    if (busy  !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done  !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks += 2;
    if (tx    !== 1'b1) begin failures++; $display("FAIL idle_tx got=%b exp=1", tx); end
    if (ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", ready); end
  endtask

  task automatic test_8n1();
    int d0;
    d0 = done_total;
    send(8'h55, 3'd7, 2'b00, 1'b0);
    valid = 1'b0;
    wait_idle("8n1");
    checks += 2;
    if (last_sticks != 160) begin failures++; $display("FAIL 8n1_sticks got=%0d exp=160", last_sticks); end
    if (done_total - d0 != 1) begin failures++; $display("FAIL 8n1_dones got=%0d exp=1", done_total - d0); end
  endtask

  task automatic test_7e2();
    send(8'h41, 3'd6, 2'b01, 1'b1);
    valid = 1'b0;
    wait_idle("7e2");
    checks++;
    if (last_sticks != 176) begin failures++; $display("FAIL 7e2_sticks got=%0d exp=176", last_sticks); end
  endtask

  task automatic test_5o1_cfg_change();
    send(8'hFF, 3'd4, 2'b10, 1'b0);
    valid = 1'b0;
    data  = 8'h00;            // cfg/data changes mid-frame must be ignored
    dbits = 3'd7;
    par   = 2'b00;
    stop2 = 1'b1;
    wait_idle("5o1");
    checks++;
    if (last_sticks != 128) begin failures++; $display("FAIL 5o1_sticks got=%0d exp=128", last_sticks); end
  endtask

  task automatic test_back_to_back();
    int d0, h0;
    d0 = done_total;
    h0 = b2b_hits;
    send(8'hA5, 3'd7, 2'b00, 1'b0);
    send(8'h3C, 3'd7, 2'b00, 1'b0);
    send(8'h00, 3'd7, 2'b00, 1'b0);
    valid = 1'b0;
    wait_idle("b2b");
    checks += 2;
    if (b2b_hits - h0 != 2) begin failures++; $display("FAIL b2b_gapless got=%0d exp=2", b2b_hits - h0); end
    if (done_total - d0 != 3) begin failures++; $display("FAIL b2b_dones got=%0d exp=3", done_total - d0); end
  endtask

  task automatic test_stick_gaps();
    rand_gap = 1'b1;
    gap_max  = 7;
    send(8'($urandom_range(255, 0)), 3'd7, 2'b00, 1'b0);
    valid = 1'b0;
    wait_idle("gaps");
    checks++;
    if (last_sticks != 160) begin failures++; $display("FAIL gaps_sticks got=%0d exp=160", last_sticks); end
    rand_gap = 1'b0;
    gap_max  = 1;
  endtask

  task automatic test_random_cfg();
    for (int i = 0; i < 4; i++) begin
      logic [DBW-1:0] db;
      logic [1:0]     p;
      logic           s2;
      int             want;
      db   = DBW'($urandom_range(7, 0));
      p    = 2'($urandom_range(3, 0));
      s2   = 1'($urandom_range(1, 0));
      want = (2 + int'(db) + 1 + ((p != 2'b00) ? 1 : 0) + int'(s2)) * OS;
      send(8'($urandom_range(255, 0)), db, p, s2);
      valid = 1'b0;
      wait_idle("rand");
      checks++;
      if (last_sticks != want) begin
        failures++;
        $display("FAIL rand_sticks got=%0d exp=%0d", last_sticks, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0, n;
    n = 0;
    send(8'h0F, 3'd7, 2'b01, 1'b0);
    valid = 1'b0;
    while (scnt < 56 && n < 5000) begin
      @(negedge clk); #2;
      n++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks += 3;
    if (tx    !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", tx); end
    if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    if (busy  !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    d0  = done_total;
    repeat (200) @(negedge clk);
    checks += 2;
    if (done_total != d0) begin failures++; $display("FAIL midrst_done got=%0d exp=%0d", done_total, d0); end
    if (tx !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", tx); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int ticks, bad, n;
    ticks = 0;
    bad   = 0;
    n     = 0;
    @(posedge clk); #1;
    brk = 1'b1;
    @(negedge clk);
    while (ticks < 3 * OS && n < 5000) begin
      @(negedge clk);
      n++;
      if (tx !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) bad++;
      if (stick) ticks++;
    end
    @(posedge clk); #1;
    brk   = 1'b0;
    ticks = 0;
    n     = 0;
    @(negedge clk);
    @(negedge clk);
    while (!ready && n < 5000) begin
      if (tx !== 1'b1) bad++;
      if (stick) ticks++;
      @(negedge clk);
      n++;
    end
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL break_line got=%0d exp=0", bad); end
    if (ticks != OS) begin failures++; $display("FAIL break_mark got=%0d exp=%0d", ticks, OS); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    dbits = 3'd7;
    par   = 2'b00;
    stop2 = 1'b0;
    brk   = 1'b0;
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1_cfg_change();
    test_back_to_back();
    test_stick_gaps();
    test_random_cfg();
    test_reset_mid();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
